// File: rtl/data_cache_ctrl_if.sv
// Processor-side and backing-memory-side signals of the data cache controller.
// Processor: rd/wr accepted only while stall=0; done pulses once per accepted request.
interface data_cache_ctrl_if;
   logic        rd;
   logic        wr;
   logic [15:0] addr;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        done;
   logic        stall;
   logic        cache_req;
   logic        cache_hit;
   logic        err;
   // Memory: mem_req and its payload stay stable until mem_ack is sampled high.
   logic        mem_req;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_ack;

   modport slave (
      input  rd, wr, addr, data_in, mem_rdata, mem_ack,
      output data_out, done, stall, cache_req, cache_hit, err,
             mem_req, mem_wr, mem_addr, mem_wdata
   );

   modport master (
      output rd, wr, addr, data_in, mem_rdata, mem_ack,
      input  data_out, done, stall, cache_req, cache_hit, err,
             mem_req, mem_wr, mem_addr, mem_wdata
   );
endinterface

// File: rtl/data_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller with
// 4 x 16-bit words per line and a word-serial backing-memory interface.
module data_cache_ctrl #(
   parameter int INDEX_BITS = 5
) (
   input  logic             clk,
   input  logic             rst,
   data_cache_ctrl_if.slave bus,
   output logic [2:0]       dbgState
);
   localparam int LINES    = 1 << INDEX_BITS;
   localparam int TAG_BITS = 13 - INDEX_BITS;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COMPARE = 3'd1,
      WB      = 3'd2,
      ALLOC   = 3'd3,
      FINISH  = 3'd4
   } stateT;

   stateT state, nextState;

   logic                  reqRd, reqWr;
   logic [15:0]           reqAddr, reqData;
   logic [1:0]            offset;
   logic [LINES-1:0]      validBits, dirtyBits;
   logic [TAG_BITS-1:0]   tagArr  [LINES];
   logic [15:0]           dataArr [LINES*4];

   logic [INDEX_BITS-1:0] reqIndex;
   logic [TAG_BITS-1:0]   reqTag;
   logic [1:0]            reqOff;
   logic [INDEX_BITS+1:0] wordSel, fillSel;
   logic                  hit, illegal, victimDirty, lastWord;

   assign reqIndex    = reqAddr[3+INDEX_BITS-1:3];
   assign reqTag      = reqAddr[15:3+INDEX_BITS];
   assign reqOff      = reqAddr[2:1];
   assign wordSel     = {reqIndex, reqOff};
   assign fillSel     = {reqIndex, offset};
   assign hit         = validBits[reqIndex] && (tagArr[reqIndex] == reqTag);
   assign illegal     = reqAddr[0] | (reqRd & reqWr);
   assign victimDirty = validBits[reqIndex] & dirtyBits[reqIndex];
   assign lastWord    = bus.mem_ack && (offset == 2'd3);
   assign dbgState    = state;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nextState;
   end

   always_comb begin
      nextState     = state;
      bus.data_out  = '0;
      bus.done      = 1'b0;
      bus.stall     = 1'b1;
      bus.cache_req = 1'b0;
      bus.cache_hit = 1'b0;
      bus.err       = 1'b0;
      bus.mem_req   = 1'b0;
      bus.mem_wr    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      case (state)
         IDLE: begin
            bus.stall = 1'b0;
            // Reset wins over a request arriving in the same cycle.
            if (!rst && (bus.rd || bus.wr)) begin
               bus.cache_req = 1'b1;
               nextState     = COMPARE;
            end
         end
         COMPARE: begin
            if (illegal) begin
               bus.done  = 1'b1;
               bus.err   = 1'b1;
               nextState = IDLE;
            end else if (hit) begin
               bus.done      = 1'b1;
               bus.cache_hit = 1'b1;
               bus.data_out  = reqRd ? dataArr[wordSel] : 16'h0000;
               nextState     = IDLE;
            end else begin
               nextState = victimDirty ? WB : ALLOC;
            end
         end
         WB: begin
            bus.mem_req   = 1'b1;
            bus.mem_wr    = 1'b1;
            bus.mem_addr  = {tagArr[reqIndex], reqIndex, offset, 1'b0};
            bus.mem_wdata = dataArr[fillSel];
            if (lastWord) nextState = ALLOC;
         end
         ALLOC: begin
            bus.mem_req  = 1'b1;
            bus.mem_addr = {reqTag, reqIndex, offset, 1'b0};
            if (lastWord) nextState = FINISH;
         end
         FINISH: begin
            bus.done     = 1'b1;
            bus.data_out = reqRd ? dataArr[wordSel] : 16'h0000;
            nextState    = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   // Request capture, burst offset counter and line arrays.
   always_ff @(posedge clk) begin
      if (rst) begin
         validBits <= '0;
         dirtyBits <= '0;
         offset    <= 2'd0;
         reqRd     <= 1'b0;
         reqWr     <= 1'b0;
         reqAddr   <= '0;
         reqData   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.rd || bus.wr) begin
                  reqRd   <= bus.rd;
                  reqWr   <= bus.wr;
                  reqAddr <= bus.addr;
                  reqData <= bus.data_in;
               end
            end
            COMPARE: begin
               if (!illegal && hit && reqWr) begin
                  dataArr[wordSel]    <= reqData;
                  dirtyBits[reqIndex] <= 1'b1;
               end
            end
            WB: begin
               if (bus.mem_ack) offset <= offset + 2'd1;
            end
            ALLOC: begin
               if (bus.mem_ack) begin
                  dataArr[fillSel] <= bus.mem_rdata;
                  offset           <= offset + 2'd1;
                  if (offset == 2'd3) begin
                     validBits[reqIndex] <= 1'b1;
                     dirtyBits[reqIndex] <= 1'b0;
                     tagArr[reqIndex]    <= reqTag;
                  end
               end
            end
            FINISH: begin
               if (reqWr) begin
                  dataArr[wordSel]    <= reqData;
                  dirtyBits[reqIndex] <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/data_cache_ctrl.md
DATA_CACHE_CTRL -- requirements
Module: data_cache_ctrl

Interface
REQ-001 SHALL have parameter INDEX_BITS, default 5, meaning number of index bits (2^INDEX_BITS lines); tag width = 13-INDEX_BITS.
REQ-002 SHALL have clk  input  1  sole clock; all state changes on posedge clk.
REQ-003 SHALL have rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have rd  input  1  processor read request.
REQ-005 SHALL have wr  input  1  processor write request.
REQ-006 SHALL have addr  input  16  byte address; offset addr[2:1], index addr[3+INDEX_BITS-1:3], tag addr[15:3+INDEX_BITS].
REQ-007 SHALL have data_in  input  16  write data.
REQ-008 SHALL have data_out  output  16  read data, valid only while done=1 for a read.
REQ-009 SHALL have done  output  1  one-cycle completion pulse.
REQ-010 SHALL have stall  output  1  high while a request is in flight; processor holds its inputs.
REQ-011 SHALL have cache_req  output  1  one-cycle pulse on request acceptance (feeds DCacheReq count).
REQ-012 SHALL have cache_hit  output  1  high with done when the access hit on first lookup (feeds DCacheHit count).
REQ-013 SHALL have err  output  1  high with done for an illegal request.
REQ-014 SHALL have mem_req, mem_wr  output  1 each  backing-memory word request and direction.
REQ-015 SHALL have mem_addr  output  16, mem_wdata  output  16, mem_rdata  input  16, mem_ack  input  1.

Function
REQ-016 SHALL be direct-mapped, write-back, write-allocate; 4 x 16-bit words per line; per-line valid, dirty, tag.
REQ-017 SHALL implement states IDLE, COMPARE, WB, ALLOC, FINISH.
REQ-018 IDLE: rd|wr high accepts request (cache_req=1 that cycle), captures rd/wr/addr/data_in, goes to COMPARE; stall=0 only in IDLE.
REQ-019 COMPARE, illegal request (addr[0]=1, or rd&wr both high): done=1, err=1, cache_hit=0, no array/memory change, go IDLE.
REQ-020 COMPARE, hit (valid & tag match): done=1, cache_hit=1; read drives word; write updates word, sets dirty; go IDLE (hit latency 2 cycles from acceptance to done).
REQ-021 COMPARE, miss: to WB if victim valid&dirty, else ALLOC.
REQ-022 WB: writes victim words offset 0..3 at {victim_tag, index, offset, 1'b0}, mem_wr=1; then ALLOC.
REQ-023 ALLOC: reads words offset 0..3 at {req_tag, index, offset, 1'b0}, mem_wr=0, into line; sets valid, tag, clears dirty; then FINISH.
REQ-024 FINISH: performs captured access on filled line (write sets dirty); done=1, cache_hit=0; go IDLE.
REQ-025 Memory handshake: mem_req, mem_addr, mem_wr, mem_wdata held stable until mem_ack=1 sampled; word completes on that edge; next word requested the following cycle; mem_ack while mem_req=0 ignored.
REQ-026 Word offset counter SHALL wrap 3->0 on last word of each WB/ALLOC burst; no extra cycles between bursts beyond one state transition.
REQ-027 New rd/wr while stall=1 SHALL be ignored; the captured request only is serviced.
REQ-028 done, cache_hit, err, cache_req SHALL be mutually consistent: cache_hit and err only with done; never both.

Reset
REQ-029 rst=1 SHALL force IDLE, clear all valid and dirty bits, offset counter 0, and drive data_out=0, done=0, stall=0, cache_req=0, cache_hit=0, err=0, mem_req=0, mem_wr=0, mem_addr=0, mem_wdata=0.
REQ-030 rst mid-burst SHALL abandon the transaction next edge (mem_req low), no done pulse; rst dominates rd/wr same cycle.

Verification
REQ-031 Cold read addr=0x0010, memory words 0x1111..0x4444 at 0x0010..0x0016, mem_ack immediate -> 4 reads, done with cache_hit=0, data_out=0x1111, no WB.
REQ-032 Subsequent read addr=0x0014 -> done 2 cycles after acceptance, cache_hit=1, data_out=0x3333, mem_req never asserted.
REQ-033 Write 0xBEEF to 0x0012 (hit), then read 0x2012 (same index, other tag) -> WB burst writes 0x1111,0xBEEF,0x3333,0x4444 to 0x0010..0x0016, then ALLOC from 0x2010.
REQ-034 Read addr=0x0011 -> done=1, err=1 in COMPARE cycle, no memory traffic; rd=wr=1 -> same.
REQ-035 mem_ack delayed 3 cycles per word -> mem_addr/mem_wdata stable throughout, stall high, single done pulse at end.
REQ-036 rst asserted during 2nd ALLOC word -> next cycle all outputs at reset values; then read same addr -> miss (cache_hit=0).
